// File: rtl/j3_pin_receiver.sv
// j3_pin_receiver
//   Receives the asynchronous J3 pin level. It synchronizes and debounces the
//   level, strobes once on each accepted rising edge, and counts those edges
//   in two BCD digits with a sticky wrap flag.
//
// Parameters
//   DEB_LEN  consecutive equal synchronized samples needed to accept a level
//            change (2..1048575)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   pin_in    asynchronous external pin level
//   clr       synchronous clear of the BCD counter and ovf
//   led       debounced pin level
//   pulse     one-cycle strobe on each accepted rising edge
//   cnt_tens  BCD tens digit of accepted rising edges
//   cnt_ones  BCD ones digit of accepted rising edges
//   ovf       sticky flag, set when the counter wraps from 99 to 00
module j3_pin_receiver #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_in,
  input  logic       clr,
  output logic       led,
  output logic       pulse,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       ovf
);

  localparam int CW = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);

  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;

  logic          s1, s2;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer. Nothing else touches pin_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // Debounce next state. The sample that leaves LOW or HIGH counts as sample
  // 1, so the FSM accepts the change on the sample where count == DEB_LEN-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: begin
        if (s2) begin
          state_d = CHK_HIGH;
          cnt_d   = CW'(1);
        end
      end
      CHK_HIGH: begin
        if (!s2)               state_d = LOW;
        else if (cnt_q == LAST) state_d = HIGH;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      HIGH: begin
        if (!s2) begin
          state_d = CHK_LOW;
          cnt_d   = CW'(1);
        end
      end
      CHK_LOW: begin
        if (s2)                state_d = HIGH;
        else if (cnt_q == LAST) state_d = LOW;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = LOW;
    endcase
  end

  // led and pulse are registered from the next state. This makes them change
  // on the same edge where the FSM accepts the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      led     <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led     <= (state_d == HIGH) || (state_d == CHK_LOW);
      // A bounce back from CHK_LOW is not a new edge, so only count entry from CHK_HIGH.
      pulse   <= (state_q == CHK_HIGH) && (state_d == HIGH);
    end
  end

  // BCD edge counter. clr takes priority over a simultaneous pulse.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_tens <= 4'd0;
      cnt_ones <= 4'd0;
      ovf      <= 1'b0;
    end else if (pulse) begin
      if (cnt_ones == 4'd9) begin
        cnt_ones <= 4'd0;
        if (cnt_tens == 4'd9) begin
          cnt_tens <= 4'd0;
          ovf      <= 1'b1;
        end else begin
          cnt_tens <= cnt_tens + 4'd1;
        end
      end else begin
        cnt_ones <= cnt_ones + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_j3_pin_receiver.sv
// Directed bench for j3_pin_receiver with DEB_LEN=4. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_j3_pin_receiver;

  logic       clk = 1'b0;
  logic       rst, pin_in, clr;
  logic       led, pulse, ovf;
  logic [3:0] cnt_tens, cnt_ones;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pulse = 0;
  int n_bad_digit = 0;

  j3_pin_receiver #(.DEB_LEN(4)) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .clr(clr),
    .led(led), .pulse(pulse), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Counts every strobe and every out-of-range BCD digit.
  always @(posedge clk) begin
    if (pulse) n_pulse++;
    if (cnt_tens > 4'd9 || cnt_ones > 4'd9) n_bad_digit++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int bcd();
    return cnt_tens * 10 + cnt_ones;
  endfunction

  // One clean pulse: 10 cycles high, then 10 cycles low. The counter is
  // settled when the task returns.
  task automatic clean_pulse();
    pin_in = 1'b1;
    tick(10);
    pin_in = 1'b0;
    tick(10);
  endtask

  int p0;

  initial begin
    rst = 1'b1; pin_in = 1'b0; clr = 1'b0;
    tick(2);
    chk("rst_led",   led,   0);
    chk("rst_pulse", pulse, 0);
    chk("rst_cnt",   bcd(), 0);
    chk("rst_ovf",   ovf,   0);
    rst = 1'b0;
    tick(3);

    // First rising edge: led and pulse rise on edge 6, and pulse drops on edge 7.
    pin_in = 1'b1;
    tick(5);
    chk("rise_e5_led", led, 0);
    tick(1);
    chk("rise_e6_led",   led,   1);
    chk("rise_e6_pulse", pulse, 1);
    tick(1);
    chk("rise_e7_pulse", pulse, 0);
    chk("rise_cnt",      bcd(), 1);
    chk("rise_ovf",      ovf,   0);
    tick(13);
    pin_in = 1'b0;
    tick(5);
    chk("fall_e5_led", led, 1);
    tick(1);
    chk("fall_e6_led", led, 0);
    tick(10);

    // A short high glitch is ignored.
    p0 = n_pulse;
    pin_in = 1'b1; tick(3);
    pin_in = 1'b0; tick(12);
    chk("hi_glitch_led",   led,     0);
    chk("hi_glitch_cnt",   bcd(),   1);
    chk("hi_glitch_pulse", n_pulse, p0);

    // A short low glitch while led is high is also ignored.
    pin_in = 1'b1; tick(12);
    chk("pre_lo_glitch_cnt", bcd(), 2);
    p0 = n_pulse;
    pin_in = 1'b0; tick(3);
    pin_in = 1'b1; tick(12);
    chk("lo_glitch_led",   led,     1);
    chk("lo_glitch_cnt",   bcd(),   2);
    chk("lo_glitch_pulse", n_pulse, p0);
    pin_in = 1'b0; tick(10);

    // A plain clear.
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_cnt", bcd(), 0);
    chk("clr_led", led, 0);

    // clr in the same cycle as the pulse that would take the counter 37 -> 38.
    repeat (37) clean_pulse();
    chk("cnt_37", bcd(), 37);
    pin_in = 1'b1;
    tick(6);
    chk("clrpulse_pulse", pulse, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clrpulse_cnt", bcd(), 0);
    chk("clrpulse_ovf", ovf,   0);
    chk("clrpulse_led", led,   1);
    tick(5);
    pin_in = 1'b0;
    tick(10);

    // Counter wrap at 99 -> 00.
    repeat (99) clean_pulse();
    chk("wrap_99_cnt", bcd(), 99);
    chk("wrap_99_ovf", ovf,   0);
    clean_pulse();
    chk("wrap_100_cnt", bcd(), 0);
    chk("wrap_100_ovf", ovf,   1);
    clean_pulse();
    chk("wrap_101_cnt", bcd(), 1);
    chk("wrap_101_ovf", ovf,   1);

    // Reset during CHK_HIGH at count=2, with pin_in held high through reset.
    pin_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("rstmid_led",   led,   0);
    chk("rstmid_pulse", pulse, 0);
    chk("rstmid_cnt",   bcd(), 0);
    chk("rstmid_ovf",   ovf,   0);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk("rstmid_e5_led", led, 0);
    tick(1);
    chk("rstmid_e6_led",   led,   1);
    chk("rstmid_e6_pulse", pulse, 1);
    tick(1);
    chk("rstmid_cnt_after", bcd(), 1);
    chk("rstmid_ovf_after", ovf,   0);

    // Clearing after an overflow drops the flag.
    pin_in = 1'b0; tick(10);
    repeat (99) clean_pulse();
    chk("ovf2_set", ovf, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("ovf2_clr_ovf", ovf,   0);
    chk("ovf2_clr_cnt", bcd(), 0);

    chk("bcd_range", n_bad_digit, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
